operand_fetch: RTL and testbench

- Issue-side stage that drives the register file's read ports. It captures source operands and hands them downstream through a one-entry pipeline register with valid/ready handshakes.
- Keeps a per-register busy scoreboard so an instruction never reads a register whose producer has not yet written back.
- Snoops the same writeback bus that drives the register file's write ports, to clear busy bits and (optionally) bypass results.

---
 rtl/rf_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 43 ++++
 rtl/operand_fetch.sv | 109 ++++++++++
 tb/tb_operand_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file wide constants and types shared by the issue stage and the register file.
package rf_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: clears from writeback ports, one set from issue, combinational queries.
module reg_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned CLR_PORTS   = 1,
   parameter int unsigned QUERY_PORTS = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [CLR_PORTS-1:0]                  clr_en,
   input  logic [CLR_PORTS-1:0][ADDR_WIDTH-1:0]  clr_addr,
   input  logic                                  set_en,
   input  logic [ADDR_WIDTH-1:0]                 set_addr,
   input  logic [QUERY_PORTS-1:0][ADDR_WIDTH-1:0] query_addr,
   output logic [QUERY_PORTS-1:0]                query_busy_c
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Clears first so a same-cycle set of the same register wins; r0 never busy.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned p = 0; p < CLR_PORTS; p++) begin
         if (clr_en[p]) busy_d[clr_addr[p]] = 1'b0;
      end
      if (set_en) busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   always_comb begin
      query_busy_c = '0;
      for (int unsigned q = 0; q < QUERY_PORTS; q++) begin
         query_busy_c[q] = busy_q[query_addr[q]];
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded register reads into a one-entry valid/ready output register.
// Optional writeback-to-operand bypass enabled by defining OPERAND_FETCH_BYPASS_EN.
module operand_fetch
   import rf_pkg::*;
#(
   parameter int unsigned READ_PORTS  = 2,
   parameter int unsigned WRITE_PORTS = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  in_src_addrs,
   input  logic [ADDR_WIDTH-1:0]                  in_dst_addr,
   input  logic                                   in_dst_en,
   output logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  rf_read_addrs,
   input  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rf_read_data,
   input  logic [WRITE_PORTS-1:0]                 wb_valid,
   input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wb_addr,
   input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wb_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  out_operands,
   output logic [ADDR_WIDTH-1:0]                  out_dst_addr,
   output logic                                   out_dst_en
);

   logic [READ_PORTS:0][ADDR_WIDTH-1:0] query_addr;
   logic [READ_PORTS:0]                 query_busy;
   logic [READ_PORTS-1:0]               byp_hit;
   logic [READ_PORTS-1:0][DATA_WIDTH-1:0] byp_data;
   logic [READ_PORTS-1:0]               src_hazard;
   logic [READ_PORTS-1:0][DATA_WIDTH-1:0] operand_sel;
   logic                                dst_hazard;
   logic                                accept;
   logic                                set_en;

   assign rf_read_addrs = in_src_addrs;
   assign query_addr    = {in_dst_addr, in_src_addrs};

   reg_scoreboard #(
      .CLR_PORTS   (WRITE_PORTS),
      .QUERY_PORTS (READ_PORTS + 1)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .clr_en       (wb_valid),
      .clr_addr     (wb_addr),
      .set_en       (set_en),
      .set_addr     (in_dst_addr),
      .query_addr   (query_addr),
      .query_busy_c (query_busy)
   );

`ifdef OPERAND_FETCH_BYPASS_EN
   // Highest matching writeback port wins, mirroring register file write order.
   always_comb begin
      byp_hit  = '0;
      byp_data = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (wb_valid[p] && (wb_addr[p] == in_src_addrs[i])) begin
               byp_hit[i]  = 1'b1;
               byp_data[i] = wb_data[p];
            end
         end
      end
   end
`else
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
   assign byp_hit        = '0;
   assign byp_data       = '0;
`endif

   always_comb begin
      src_hazard  = '0;
      operand_sel = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         if (in_src_addrs[i] == '0)  operand_sel[i] = '0;
         else if (byp_hit[i])        operand_sel[i] = byp_data[i];
         else                        operand_sel[i] = rf_read_data[i];
         src_hazard[i] = query_busy[i] && (in_src_addrs[i] != '0) && !byp_hit[i];
      end
   end

   // One busy bit per register, so a second writer must wait for the first to retire.
   assign dst_hazard = in_dst_en && (in_dst_addr != '0) && query_busy[READ_PORTS];
   assign in_ready   = (!out_valid || out_ready) && !(|src_hazard) && !dst_hazard;
   assign accept     = in_valid && in_ready;
   assign set_en     = accept && in_dst_en && (in_dst_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_operands <= '0;
         out_dst_addr <= '0;
         out_dst_en   <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_operands <= operand_sel;
         out_dst_addr <= in_dst_addr;
         out_dst_en   <= in_dst_en;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic against a reference model.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0][4:0]  in_src_addrs;
   logic [4:0]       in_dst_addr;
   logic             in_dst_en;
   logic [1:0][4:0]  rf_read_addrs;
   logic [1:0][31:0] rf_read_data;
   logic [0:0]       wb_valid;
   logic [0:0][4:0]  wb_addr;
   logic [0:0][31:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [1:0][31:0] out_operands;
   logic [4:0]       out_dst_addr;
   logic             out_dst_en;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_src_addrs  (in_src_addrs),
      .in_dst_addr   (in_dst_addr),
      .in_dst_en     (in_dst_en),
      .rf_read_addrs (rf_read_addrs),
      .rf_read_data  (rf_read_data),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_operands  (out_operands),
      .out_dst_addr  (out_dst_addr),
      .out_dst_en    (out_dst_en)
   );

   // Register file model; r0 returns junk so the stage must zero it by itself.
   bit [31:0] rf [32];
   always @(posedge clk) if (wb_valid[0] && wb_addr[0] != 5'd0) rf[wb_addr[0]] <= wb_data[0];
   always_comb begin
      for (int i = 0; i < 2; i++)
         rf_read_data[i] = (rf_read_addrs[i] == 5'd0) ? 32'hDEAD_0000 : rf[rf_read_addrs[i]];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: set of registers with an outstanding producer, plus the output slot.
   bit        m_valid;
   bit [31:0] m_op [2];
   bit [4:0]  m_dst;
   bit        m_dst_en;
   bit [31:0] m_busy;
   logic      rdy_seen;

   task automatic model_reset();
      m_valid = 0; m_op[0] = 0; m_op[1] = 0; m_dst = 0; m_dst_en = 0; m_busy = 0;
   endtask

   // One cycle: drive at negedge, check in_ready, advance model, check outputs at next negedge.
   task automatic step(input int v, input int s0, input int s1, input int d, input int de,
                       input int orr, input int wv, input int wa, input logic [31:0] wd,
                       input int r);
      int        src [2];
      bit [31:0] op [2];
      bit        hz, hit, exp_rdy, acc;
      in_valid        = 1'(v);
      in_src_addrs[0] = 5'(s0);
      in_src_addrs[1] = 5'(s1);
      in_dst_addr     = 5'(d);
      in_dst_en       = 1'(de);
      out_ready       = 1'(orr);
      wb_valid[0]     = 1'(wv);
      wb_addr[0]      = 5'(wa);
      wb_data[0]      = wd;
      rst             = 1'(r);
      #1;
      src[0] = s0; src[1] = s1;
      hz = 0;
      for (int i = 0; i < 2; i++) begin
         hit = BYP && (wv != 0) && (wa == src[i]);
         if (src[i] != 0 && m_busy[src[i]] && !hit) hz = 1;
         op[i] = (src[i] == 0) ? 32'd0 : (hit ? wd : rf[src[i]]);
      end
      if (de != 0 && d != 0 && m_busy[d]) hz = 1;
      exp_rdy = (!m_valid || orr != 0) && !hz;
      acc = (v != 0) && exp_rdy;
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      check_eq("rf_read_addrs", 64'(rf_read_addrs), 64'({5'(s1), 5'(s0)}));
      rdy_seen = in_ready;
      if (r != 0) model_reset();
      else begin
         if (acc) begin
            m_valid = 1; m_op[0] = op[0]; m_op[1] = op[1]; m_dst = 5'(d); m_dst_en = (de != 0);
         end else if (orr != 0) m_valid = 0;
         if (wv != 0) m_busy[wa] = 0;
         if (acc && de != 0 && d != 0) m_busy[d] = 1;
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("out_valid", 64'(out_valid), 64'(m_valid));
      check_eq("out_op0", 64'(out_operands[0]), 64'(m_op[0]));
      check_eq("out_op1", 64'(out_operands[1]), 64'(m_op[1]));
      check_eq("out_dst_addr", 64'(out_dst_addr), 64'(m_dst));
      check_eq("out_dst_en", 64'(out_dst_en), 64'(m_dst_en));
   endtask

   task automatic idle(input int wv, input int wa, input logic [31:0] wd);
      step(0, 0, 0, 0, 0, 1, wv, wa, wd, 0);
   endtask

   initial begin
      rst = 1; in_valid = 0; in_src_addrs = '0; in_dst_addr = 0; in_dst_en = 0;
      out_ready = 1; wb_valid = '0; wb_addr = '0; wb_data = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("reset_out_valid", 64'(out_valid), 64'd0);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      check_eq("reset_in_ready", 64'(rdy_seen), 64'd1);

      // Basic read of r3/r4
      idle(1, 3, 10);
      idle(1, 4, 20);
      step(1, 3, 4, 0, 0, 1, 0, 0, 0, 0);
      check_eq("basic_rdy", 64'(rdy_seen), 64'd1);
      check_eq("basic_valid", 64'(out_valid), 64'd1);
      check_eq("basic_op", 64'(out_operands), {32'd20, 32'd10});
      idle(0, 0, 0);
      check_eq("basic_drain", 64'(out_valid), 64'd0);

      // RAW on r5
      step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      check_eq("raw_stall", 64'(rdy_seen), 64'd0);
      step(1, 5, 0, 0, 0, 1, 1, 5, 32'hAB, 0);
      if (BYP) begin
         check_eq("raw_byp_rdy", 64'(rdy_seen), 64'd1);
      end else begin
         check_eq("raw_wb_stall", 64'(rdy_seen), 64'd0);
         step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
         check_eq("raw_rf_rdy", 64'(rdy_seen), 64'd1);
      end
      check_eq("raw_op0", 64'(out_operands[0]), 64'hAB);
      idle(0, 0, 0);

      // Backpressure
      step(1, 3, 4, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 4, 3, 0, 0, 0, 0, 0, 0, 0);
         check_eq("bp_stall", 64'(rdy_seen), 64'd0);
         check_eq("bp_hold", 64'(out_operands), {32'd20, 32'd10});
      end
      step(1, 4, 3, 0, 0, 1, 0, 0, 0, 0);
      check_eq("bp_release", 64'(rdy_seen), 64'd1);
      check_eq("bp_op", 64'(out_operands), {32'd10, 32'd20});
      idle(0, 0, 0);

      // Register zero
      step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 1, 0, 32'hFF, 0);
      check_eq("r0_rdy", 64'(rdy_seen), 64'd1);
      check_eq("r0_op", 64'(out_operands[0]), 64'd0);

      // Set/clear collision on r7
      step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 7, 1, 1, 1, 7, 32'h77, 0);
      check_eq("coll_waw_stall", 64'(rdy_seen), 64'd0);
      step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
      check_eq("coll_accept", 64'(rdy_seen), 64'd1);
      step(1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
      check_eq("coll_src_stall", 64'(rdy_seen), 64'd0);

      // Reset mid-operation
      step(1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      check_eq("midrst_valid_before", 64'(out_valid), 64'd1);
      step(1, 1, 1, 3, 1, 0, 1, 2, 32'h5, 1);
      check_eq("midrst_valid", 64'(out_valid), 64'd0);
      step(1, 2, 9, 7, 1, 0, 0, 0, 0, 0);
      check_eq("midrst_rdy", 64'(rdy_seen), 64'd1);
      idle(0, 0, 0);

      // Random traffic over a small register window to provoke hazards
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 9) < 7) ? 1 : 0,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0) ? 1 : 0,
              ($urandom_range(0, 9) < 4) ? 1 : 0,
              int'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 299) == 0) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
